// File: rtl/lbr_unit_if.sv
// Request/response and commit-side signals between the memory stage and
// the Last Branch Record unit. The memory stage is the master; the LBR
// unit is the slave.
interface lbr_unit_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int LBR_DATA_WIDTH = 64,
    parameter int LBR_INDEX_BITS = 4
);
    logic                      stall;
    logic                      lbr_enable;
    logic                      branch_commit;
    logic [1:0]                next_PC_sel;
    logic [DATA_WIDTH-1:0]     PC_address;
    logic [DATA_WIDTH-1:0]     target_address;
    logic [1:0]                lbrReq;
    logic [DATA_WIDTH-1:0]     RW_address;
    logic                      report;
    logic [LBR_DATA_WIDTH-1:0] lbr_data;
    logic                      lbr_valid;
    logic [LBR_INDEX_BITS:0]   lbr_count;
    logic                      lbr_overflow;

    modport master (
        output stall, lbr_enable, branch_commit, next_PC_sel, PC_address,
               target_address, lbrReq, RW_address, report,
        input  lbr_data, lbr_valid, lbr_count, lbr_overflow
    );

    modport slave (
        input  stall, lbr_enable, branch_commit, next_PC_sel, PC_address,
               target_address, lbrReq, RW_address, report,
        output lbr_data, lbr_valid, lbr_count, lbr_overflow
    );
endinterface

// File: rtl/lbr_unit.sv
// Last Branch Record unit: records every committed control transfer as a
// {from_PC, to_PC} pair in a circular buffer and answers read / status /
// clear requests from the memory stage with a registered one-cycle reply.
module lbr_unit #(
    parameter int CORE           = 0,
    parameter int DATA_WIDTH     = 32,
    parameter int LBR_DATA_WIDTH = 64,
    parameter int LBR_SIZE       = 16,
    parameter int LBR_INDEX_BITS = 4
) (
    input  logic       clock,
    input  logic       reset,
    lbr_unit_if.slave  bus
);
    localparam logic [1:0] REQ_NONE   = 2'b00;
    localparam logic [1:0] REQ_READ   = 2'b01;
    localparam logic [1:0] REQ_CLEAR  = 2'b10;
    localparam logic [1:0] REQ_STATUS = 2'b11;

    // Record storage and architectural state.
    logic [LBR_DATA_WIDTH-1:0] r_entries [LBR_SIZE];
    logic [LBR_INDEX_BITS-1:0] r_wr_ptr;
    logic [LBR_INDEX_BITS:0]   r_count;
    logic                      r_overflow;
    logic [LBR_DATA_WIDTH-1:0] r_data;
    logic                      r_valid;

    // Next-state values.
    logic [LBR_INDEX_BITS-1:0] w_wr_ptr_nxt;
    logic [LBR_INDEX_BITS:0]   w_count_nxt;
    logic                      w_overflow_nxt;
    logic [LBR_DATA_WIDTH-1:0] w_data_nxt;
    logic                      w_valid_nxt;
    logic                      w_wr_en;

    logic                      w_rec;
    logic                      w_clear;
    logic [LBR_INDEX_BITS-1:0] w_idx;
    logic [LBR_INDEX_BITS-1:0] w_phys;
    logic                      w_hit;
    logic                      w_unused;

    // A committed, non-sequential control transfer while recording is on.
    assign w_rec   = bus.lbr_enable & bus.branch_commit &
                     (bus.next_PC_sel != 2'b00) & ~bus.stall;
    assign w_clear = (bus.lbrReq == REQ_CLEAR) & ~bus.stall;

    // Logical index 0 is the newest record, i.e. the slot just behind wr_ptr.
    assign w_idx  = bus.RW_address[LBR_INDEX_BITS-1:0];
    assign w_phys = r_wr_ptr - LBR_INDEX_BITS'(1) - w_idx;
    assign w_hit  = ({1'b0, w_idx} < r_count);

    // Upper address bits and the debug-dump enable carry no function here.
    assign w_unused = ^{bus.RW_address[DATA_WIDTH-1:LBR_INDEX_BITS], bus.report};

    // Next-state and response selection; all reads observe pre-record state.
    always_comb begin
        w_wr_ptr_nxt   = r_wr_ptr;
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow;
        w_data_nxt     = r_data;
        w_valid_nxt    = 1'b0;
        w_wr_en        = 1'b0;
        if (bus.stall) begin
            w_valid_nxt = 1'b0;
        end else begin
            case (bus.lbrReq)
                REQ_READ: begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = w_hit ? r_entries[w_phys] : {LBR_DATA_WIDTH{1'b0}};
                end
                REQ_CLEAR: begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = {LBR_DATA_WIDTH{1'b0}};
                end
                REQ_STATUS: begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = LBR_DATA_WIDTH'({r_overflow, r_count, r_wr_ptr});
                end
                REQ_NONE: begin
                    w_valid_nxt = 1'b0;
                end
                default: begin
                    w_valid_nxt = 1'b0;
                end
            endcase
            // Clear beats a coincident record, which is dropped.
            if (w_clear) begin
                w_wr_ptr_nxt   = {LBR_INDEX_BITS{1'b0}};
                w_count_nxt    = {(LBR_INDEX_BITS+1){1'b0}};
                w_overflow_nxt = 1'b0;
            end else if (w_rec) begin
                w_wr_en      = 1'b1;
                w_wr_ptr_nxt = r_wr_ptr + LBR_INDEX_BITS'(1);
                if (r_count < (LBR_INDEX_BITS+1)'(LBR_SIZE)) begin
                    w_count_nxt = r_count + (LBR_INDEX_BITS+1)'(1);
                end else begin
                    w_overflow_nxt = 1'b1;
                end
            end else begin
                w_wr_en = 1'b0;
            end
        end
    end

    // Control/status registers with synchronous reset; reset drops any reply.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= {LBR_INDEX_BITS{1'b0}};
            r_count    <= {(LBR_INDEX_BITS+1){1'b0}};
            r_overflow <= 1'b0;
            r_data     <= {LBR_DATA_WIDTH{1'b0}};
            r_valid    <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    // Record storage is deliberately not reset; count gates what is visible.
    always_ff @(posedge clock) begin
        if (w_wr_en && !reset) begin
            r_entries[r_wr_ptr] <= {bus.PC_address, bus.target_address};
        end
    end

    assign bus.lbr_data     = r_data;
    assign bus.lbr_valid    = r_valid;
    assign bus.lbr_count    = r_count;
    assign bus.lbr_overflow = r_overflow;
endmodule

// File: tb/tb_lbr_unit.sv
// Self-checking bench for lbr_unit: a vector table for the single-cycle
// behaviours, plus hand-written wrap-around and reset-during-request sequences.
module tb_lbr_unit;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    lbr_unit_if bus ();

    lbr_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        stall;
        logic        en;
        logic        commit;
        logic [1:0]  sel;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [1:0]  req;
        logic [31:0] addr;
        logic        exp_valid;
        logic [63:0] exp_data;
        logic [4:0]  exp_count;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [63:0] data;
    } resp_t;

    vec_t  tbl  [$];
    resp_t sb_q [$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic en, input logic cm,
                                input logic [1:0] sel, input logic [31:0] pc,
                                input logic [31:0] tgt, input logic [1:0] req,
                                input logic [31:0] addr, input logic ev,
                                input logic [63:0] ed, input logic [4:0] ec,
                                input logic eo);
        vec_t v;
        v.stall = st; v.en = en; v.commit = cm; v.sel = sel; v.pc = pc;
        v.tgt = tgt; v.req = req; v.addr = addr; v.exp_valid = ev;
        v.exp_data = ed; v.exp_count = ec; v.exp_ovf = eo;
        return v;
    endfunction

    task automatic drive_idle();
        bus.stall = 1'b0; bus.lbr_enable = 1'b0; bus.branch_commit = 1'b0;
        bus.next_PC_sel = 2'b00; bus.PC_address = 32'h0; bus.target_address = 32'h0;
        bus.lbrReq = 2'b00; bus.RW_address = 32'h0; bus.report = 1'b0;
    endtask

    // Drive one vector for one cycle; expected reply goes through the scoreboard.
    task automatic apply(input vec_t v, input string name);
        resp_t r;
        bus.stall = v.stall; bus.lbr_enable = v.en; bus.branch_commit = v.commit;
        bus.next_PC_sel = v.sel; bus.PC_address = v.pc; bus.target_address = v.tgt;
        bus.lbrReq = v.req; bus.RW_address = v.addr;
        sb_q.push_back('{valid: v.exp_valid, data: v.exp_data});
        @(posedge clock);
        #1;
        r = sb_q.pop_front();
        check({name, ".valid"}, {63'h0, bus.lbr_valid}, {63'h0, r.valid});
        if (r.valid) check({name, ".data"}, bus.lbr_data, r.data);
        check({name, ".count"}, {59'h0, bus.lbr_count}, {59'h0, v.exp_count});
        check({name, ".ovf"}, {63'h0, bus.lbr_overflow}, {63'h0, v.exp_ovf});
        drive_idle();
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("rst.valid", {63'h0, bus.lbr_valid}, 64'h0);
        check("rst.data", bus.lbr_data, 64'h0);
        check("rst.count", {59'h0, bus.lbr_count}, 64'h0);
        check("rst.ovf", {63'h0, bus.lbr_overflow}, 64'h0);
        reset = 1'b0;

        //        st    en    cm    sel    pc       tgt      req    addr  ev    exp_data                 cnt   ovf
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 32'h0,   32'h0,   2'b11, 32'd0, 1'b1, 64'h0,                   5'd0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'b01, 32'h100, 32'h200, 2'b00, 32'd0, 1'b0, 64'h0,                   5'd1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 32'h0,   32'h0,   2'b01, 32'd0, 1'b1, 64'h00000100_00000200,   5'd1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 32'h0,   32'h0,   2'b01, 32'd1, 1'b1, 64'h0,                   5'd1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 32'h0,   32'h0,   2'b11, 32'd0, 1'b1, 64'h11,                  5'd1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'b00, 32'h900, 32'h904, 2'b00, 32'd0, 1'b0, 64'h0,                   5'd1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 2'b10, 32'h900, 32'h990, 2'b00, 32'd0, 1'b0, 64'h0,                   5'd1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 2'b11, 32'h900, 32'h990, 2'b11, 32'd0, 1'b0, 64'h0,                   5'd1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'b11, 32'h300, 32'h400, 2'b01, 32'd0, 1'b1, 64'h00000100_00000200,   5'd2, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 32'h0,   32'h0,   2'b01, 32'd0, 1'b1, 64'h00000300_00000400,   5'd2, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 32'h0,   32'h0,   2'b01, 32'd1, 1'b1, 64'h00000100_00000200,   5'd2, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'b01, 32'h500, 32'h600, 2'b11, 32'd0, 1'b1, 64'h22,                  5'd3, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'b10, 32'h700, 32'h800, 2'b10, 32'd0, 1'b1, 64'h0,                   5'd0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 32'h0,   32'h0,   2'b11, 32'd0, 1'b1, 64'h0,                   5'd0, 1'b0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Wrap-around: 17 records into a 16-entry buffer.
        for (int i = 0; i < 17; i++) begin
            apply(mk(1'b0, 1'b1, 1'b1, 2'b01, 32'h10 * i, 32'h1000 + i, 2'b00, 32'd0,
                     1'b0, 64'h0, (i < 16) ? 5'(i + 1) : 5'd16, (i == 16)),
                  $sformatf("wrap%0d", i));
        end
        apply(mk(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b01, 32'd0,  1'b1,
                 64'h00000100_00001010, 5'd16, 1'b1), "wrap.idx0");
        apply(mk(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b01, 32'd15, 1'b1,
                 64'h00000010_00001001, 5'd16, 1'b1), "wrap.idx15");
        apply(mk(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b11, 32'd0,  1'b1,
                 64'h301, 5'd16, 1'b1), "wrap.status");
        // Stalled read keeps the previous reply data and gives no valid.
        apply(mk(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b01, 32'd0,  1'b0,
                 64'h0, 5'd16, 1'b1), "wrap.stall");
        check("stall.data_hold", bus.lbr_data, 64'h301);

        // Reset arriving together with a request discards the reply.
        bus.lbrReq = 2'b11;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive_idle();
        check("rstreq.valid", {63'h0, bus.lbr_valid}, 64'h0);
        check("rstreq.count", {59'h0, bus.lbr_count}, 64'h0);
        check("rstreq.ovf", {63'h0, bus.lbr_overflow}, 64'h0);
        check("rstreq.data", bus.lbr_data, 64'h0);
        apply(mk(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b01, 32'd0, 1'b1,
                 64'h0, 5'd0, 1'b0), "rstreq.read_empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/lbr_unit.md
Name: lbr_unit

Overview:
- Last Branch Record unit beside the memory stage.
- Captures every committed control transfer (taken branch, JAL, JALR) as a {from_PC, to_PC} record into a circular buffer of LBR_SIZE entries.
- Serves read, status and clear requests issued by the memory stage via lbrReq, with a registered one-cycle response that the memory stage returns as load data.

Parameters:
- CORE, 0, core id, used in report output only.
- DATA_WIDTH, 32, PC width.
- LBR_DATA_WIDTH, 64, record width, must equal 2*DATA_WIDTH.
- LBR_SIZE, 16, number of entries, power of two.
- LBR_INDEX_BITS, 4, log2(LBR_SIZE).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- stall  in  1  pipeline stall; freezes all state updates
- lbr_enable  in  1  recording enable
- branch_commit  in  1  instruction in this stage is a valid committed control instruction
- next_PC_sel  in  2  00 PC+4, 01 branch taken, 10 JAL, 11 JALR
- PC_address  in  DATA_WIDTH  source PC of the control instruction
- target_address  in  DATA_WIDTH  destination PC
- lbrReq  in  2  00 none, 01 read entry, 10 clear, 11 read status
- RW_address  in  DATA_WIDTH  logical entry index for reads; low LBR_INDEX_BITS are used
- lbr_data  out  LBR_DATA_WIDTH  registered response data
- lbr_valid  out  1  one-cycle pulse, response valid
- lbr_count  out  LBR_INDEX_BITS+1  live entries, saturating at LBR_SIZE
- lbr_overflow  out  1  sticky; set when an old record was overwritten
- report  in  1  enables $display dump each cycle

Behaviour:
- Reset (synchronous, active-high):
  - wr_ptr=0, lbr_count=0, lbr_overflow=0, lbr_data=0, lbr_valid=0.
  - Entry storage is not cleared.
- Record condition (rec):
  - rec = lbr_enable & branch_commit & (next_PC_sel != 00) & !stall.
  - On rec: entry[wr_ptr] <= {PC_address, target_address}, with PC_address in the upper half.
  - wr_ptr <= wr_ptr+1, wrapping mod LBR_SIZE.
  - If lbr_count < LBR_SIZE, lbr_count increments; otherwise lbr_count holds and lbr_overflow <= 1.
- Read entry (lbrReq=01, !stall):
  - idx = RW_address[LBR_INDEX_BITS-1:0]. Logical index 0 is the most recent record.
  - phys = (wr_ptr - 1 - idx) mod LBR_SIZE.
  - Next cycle: lbr_valid=1 and lbr_data=entry[phys] if idx < lbr_count, else lbr_data=0.
  - Latency is exactly 1 cycle.
- Read status (lbrReq=11, !stall):
  - Next cycle: lbr_valid=1.
  - lbr_data = zero-extended {lbr_overflow, lbr_count, wr_ptr}, with wr_ptr in the LSBs.
- Clear (lbrReq=10, !stall):
  - Next cycle: wr_ptr=0, lbr_count=0, lbr_overflow=0.
  - lbr_valid=1 with lbr_data=0, as an acknowledgement.
- lbrReq=00: lbr_valid=0 next cycle; lbr_data holds its last value.
- Simultaneous events:
  - rec together with a read: the read returns pre-record state (index 0 is the previous newest). The record still commits.
  - rec together with clear: clear wins and the record is dropped.
  - rec together with status read: status reflects pre-record values.
- Stall: no record, no request is accepted, lbr_valid=0 next cycle, all other state holds.
- Wrap-around: after 17 records with LBR_SIZE=16:
  - wr_ptr=1, count=16, overflow=1.
  - Index 15 is the 2nd-oldest record; the 1st record is lost.
- Reset mid-request: reset dominates; the pending response is discarded and lbr_valid=0.
- report: prints cycle, wr_ptr, lbr_count, lbr_overflow, lbrReq, lbr_data, lbr_valid.

Test Plan:
1. Reset, then lbrReq=11 → next cycle lbr_valid=1, lbr_data=0.
2. Commit one branch (sel=01, PC=0x100, target=0x200), then read idx 0 → lbr_data=0x00000100_00000200, lbr_count=1. Read idx 1 → lbr_data=0.
3. Commit 17 records (PC=0x10*i, target=0x1000+i, i=0..16) → count=16, overflow=1, wr_ptr=1. Idx 0 returns {0x100, 0x1010}; idx 15 returns {0x10, 0x1001}.
4. Commit with sel=00, or with lbr_enable=0, or with stall=1 → count unchanged. A request under stall gives lbr_valid=0.
5. rec and lbrReq=10 in the same cycle → count=0, wr_ptr=0, overflow=0, lbr_valid=1, lbr_data=0.
6. rec (PC=0x300) and read idx 0 in the same cycle, with 0x100 as the prior newest → response {0x100, …}. The following read idx 0 returns {0x300, …}.
